// File: rtl/rc4_decrypt_fsm.sv
// RC4 keystream generation (PRGA) and decryption stage: walks the permuted S array,
// XORs each keystream byte with the ciphertext and writes the plaintext out.
module rc4_decrypt_fsm #(
  parameter int MSG_LEN     = 32,
  parameter bit CHECK_CHARS = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic       finish,
  output logic       fail,
  output logic [7:0] fail_index,
  output logic [7:0] s_addr,
  output logic [7:0] s_wr_data,
  output logic       s_wren,
  input  logic [7:0] s_q,
  output logic [7:0] e_addr,
  input  logic [7:0] e_q,
  output logic [7:0] d_addr,
  output logic [7:0] d_wr_data,
  output logic       d_wren,
  output logic [3:0] dbg_state_o
);

  localparam logic [3:0] IDLE   = 4'd0;
  localparam logic [3:0] RD_SI  = 4'd1;
  localparam logic [3:0] GET_SI = 4'd2;
  localparam logic [3:0] RD_SJ  = 4'd3;
  localparam logic [3:0] GET_SJ = 4'd4;
  localparam logic [3:0] WR_SI  = 4'd5;
  localparam logic [3:0] WR_SJ  = 4'd6;
  localparam logic [3:0] RD_F   = 4'd7;
  localparam logic [3:0] GET_F  = 4'd8;
  localparam logic [3:0] WR_D   = 4'd9;
  localparam logic [3:0] NEXT   = 4'd10;
  localparam logic [3:0] DONE   = 4'd11;

  localparam logic [7:0] LAST_K = 8'(MSG_LEN - 1);

  logic [3:0] state_q, state_d;
  logic [7:0] i_q, i_d, j_q, j_d, k_q, k_d;
  logic [7:0] si_q, si_d, sj_q, sj_d, f_q, f_d, c_q, c_d;
  logic       fail_q, fail_d;
  logic [7:0] fidx_q, fidx_d;
  logic [7:0] plain;
  logic       plain_ok;

  assign plain    = f_q ^ c_q;
  assign plain_ok = ((plain >= 8'h61) && (plain <= 8'h7A)) || (plain == 8'h20);

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    k_d     = k_q;
    si_d    = si_q;
    sj_d    = sj_q;
    f_d     = f_q;
    c_d     = c_q;
    fail_d  = fail_q;
    fidx_d  = fidx_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          i_d     = 8'd1;
          j_d     = 8'd0;
          k_d     = 8'd0;
          fail_d  = 1'b0;
          fidx_d  = 8'd0;
          state_d = RD_SI;
        end
      end
      RD_SI:  state_d = GET_SI;
      GET_SI: begin
        si_d    = s_q;
        j_d     = j_q + s_q;
        state_d = RD_SJ;
      end
      RD_SJ:  state_d = GET_SJ;
      GET_SJ: begin
        sj_d    = s_q;
        state_d = WR_SI;
      end
      WR_SI:  state_d = WR_SJ;
      WR_SJ:  state_d = RD_F;
      RD_F:   state_d = GET_F;
      GET_F: begin
        f_d     = s_q;
        c_d     = e_q;
        state_d = WR_D;
      end
      WR_D: begin
        // The bad byte has already been written this cycle; abort afterwards.
        if (CHECK_CHARS && !plain_ok) begin
          fail_d  = 1'b1;
          fidx_d  = k_q;
          state_d = DONE;
        end else begin
          state_d = NEXT;
        end
      end
      NEXT: begin
        if (k_q == LAST_K) begin
          state_d = DONE;
        end else begin
          k_d     = k_q + 8'd1;
          i_d     = i_q + 8'd1;
          state_d = RD_SI;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      i_q     <= 8'd0;
      j_q     <= 8'd0;
      k_q     <= 8'd0;
      si_q    <= 8'd0;
      sj_q    <= 8'd0;
      f_q     <= 8'd0;
      c_q     <= 8'd0;
      fail_q  <= 1'b0;
      fidx_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      k_q     <= k_d;
      si_q    <= si_d;
      sj_q    <= sj_d;
      f_q     <= f_d;
      c_q     <= c_d;
      fail_q  <= fail_d;
      fidx_q  <= fidx_d;
    end
  end

  // Memory ports are decoded from state so addresses stay stable across read/get pairs.
  always_comb begin
    s_addr    = 8'd0;
    s_wr_data = 8'd0;
    s_wren    = 1'b0;
    e_addr    = 8'd0;
    d_addr    = 8'd0;
    d_wr_data = 8'd0;
    d_wren    = 1'b0;
    case (state_q)
      RD_SI, GET_SI: s_addr = i_q;
      RD_SJ, GET_SJ: s_addr = j_q;
      WR_SI: begin
        s_addr    = i_q;
        s_wr_data = sj_q;
        s_wren    = 1'b1;
      end
      WR_SJ: begin
        s_addr    = j_q;
        s_wr_data = si_q;
        s_wren    = 1'b1;
      end
      RD_F, GET_F: begin
        s_addr = si_q + sj_q;
        e_addr = k_q;
      end
      WR_D: begin
        d_addr    = k_q;
        d_wr_data = plain;
        d_wren    = 1'b1;
      end
      default: ;
    endcase
  end

  assign finish      = (state_q == DONE);
  assign fail        = fail_q;
  assign fail_index  = fidx_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_rc4_decrypt_fsm.sv
// Bench for rc4_decrypt_fsm: synchronous memory models around the DUT and a
// textbook RC4 (KSA + PRGA) reference used to predict plaintext, S and timing.
module tb_rc4_decrypt_fsm;

  logic       clk = 1'b0;
  logic       reset, start;
  logic       finish, fail, d_wren, s_wren;
  logic [7:0] fail_index, s_addr, s_wr_data, s_q, e_addr, e_q, d_addr, d_wr_data;
  logic [3:0] dbg_state;

  rc4_decrypt_fsm #(.MSG_LEN(32), .CHECK_CHARS(1'b1)) dut (
    .clk(clk), .reset(reset), .start(start), .finish(finish), .fail(fail),
    .fail_index(fail_index), .s_addr(s_addr), .s_wr_data(s_wr_data), .s_wren(s_wren),
    .s_q(s_q), .e_addr(e_addr), .e_q(e_q), .d_addr(d_addr), .d_wr_data(d_wr_data),
    .d_wren(d_wren), .dbg_state_o(dbg_state)
  );

  always #5 clk = ~clk;

  // Memory models (synchronous read); load_mem copies the bench images in one cycle.
  logic [7:0] s_mem [256];
  logic [7:0] e_mem [256];
  logic [7:0] d_mem [256];
  logic [7:0] s_img [256];
  logic [7:0] e_img [256];
  logic       load_mem;

  always @(posedge clk) begin
    if (load_mem) begin
      s_mem <= s_img;
      e_mem <= e_img;
      for (int a = 0; a < 256; a++) d_mem[a] <= 8'hEE;
    end else begin
      if (s_wren) s_mem[s_addr] <= s_wr_data;
      if (d_wren) d_mem[d_addr] <= d_wr_data;
    end
    s_q <= s_mem[s_addr];
    e_q <= e_mem[e_addr];
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference model state
  logic [7:0] ref_s [256];
  logic [7:0] ref_d [32];
  logic [7:0] p_img [32];
  bit         ref_fail;
  int         ref_last;
  int         got_fin_cyc;
  logic       got_fail;
  logic [7:0] got_idx;
  bit         hold_start;

  function automatic bit printable(input logic [7:0] b);
    return (b == 8'h20) || (b >= 8'h61 && b <= 8'h7A);
  endfunction

  task automatic ref_model(input bit chk);
    logic [7:0] i, j, t, ks;
    ref_s    = s_img;
    i        = 8'd0;
    j        = 8'd0;
    ref_fail = 1'b0;
    ref_last = 31;
    for (int k = 0; k < 32; k++) begin
      i        = i + 8'd1;
      j        = j + ref_s[i];
      t        = ref_s[i];
      ref_s[i] = ref_s[j];
      ref_s[j] = t;
      t        = ref_s[i] + ref_s[j];
      ks       = ref_s[t];
      ref_d[k] = ks ^ e_img[k];
      if (chk && !printable(ref_d[k])) begin
        ref_fail = 1'b1;
        ref_last = k;
        break;
      end
    end
  endtask

  task automatic ksa(input logic [23:0] key);
    logic [7:0] j, t, kb;
    for (int a = 0; a < 256; a++) s_img[a] = 8'(a);
    j = 8'd0;
    for (int a = 0; a < 256; a++) begin
      kb       = (a % 3 == 0) ? key[23:16] : (a % 3 == 1) ? key[15:8] : key[7:0];
      j        = j + s_img[a] + kb;
      t        = s_img[a];
      s_img[a] = s_img[j];
      s_img[j] = t;
    end
  endtask

  task automatic identity_s();
    for (int a = 0; a < 256; a++) begin
      s_img[a] = 8'(a);
      e_img[a] = 8'h00;
    end
  endtask

  // Builds ciphertext from a random printable plaintext; bad_pos >= 0 plants an invalid byte.
  task automatic make_cipher(input int bad_pos);
    int r;
    logic [7:0] b;
    for (int a = 0; a < 256; a++) e_img[a] = 8'h00;
    ref_model(1'b0);
    for (int k = 0; k < 32; k++) begin
      r = $urandom_range(0, 26);
      p_img[k] = (r == 26) ? 8'h20 : 8'(8'h61 + r);
    end
    if (bad_pos >= 0) begin
      do b = 8'($urandom_range(0, 255)); while (printable(b));
      p_img[bad_pos] = b;
    end
    for (int k = 0; k < 32; k++) e_img[k] = p_img[k] ^ ref_d[k];
    ref_model(1'b1);
  endtask

  task automatic load_mems();
    @(negedge clk);
    load_mem = 1'b1;
    @(negedge clk);
    load_mem = 1'b0;
  endtask

  task automatic launch();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
  endtask

  function automatic logic [63:0] all_outs();
    return {8'h0, s_addr, s_wr_data, e_addr, d_addr, d_wr_data, fail_index,
            s_wren, d_wren, finish, fail};
  endfunction

  // Cycle 1 is the first cycle after the edge that accepted start.
  task automatic watch_run(input int rst_cyc);
    int nd, ns;
    bit done;
    nd = 0; ns = 0; done = 1'b0;
    for (int cyc = 1; cyc <= 400 && !done; cyc++) begin
      @(negedge clk);
      if (cyc == 1) begin
        start = hold_start;
        check("fail_clr", {63'd0, fail}, 64'd0);
        check("fidx_clr", {56'd0, fail_index}, 64'd0);
      end
      if (s_wren) ns++;
      if (d_wren) begin
        nd++;
        check("d_wr_cycle", 64'(cyc), 64'(10 * int'(d_addr) + 9));
        check("d_wr_data", {56'd0, d_wr_data}, {56'd0, ref_d[d_addr[4:0]]});
      end
      if (cyc == rst_cyc) begin
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midrun_rst_outs", all_outs(), 64'd0);
        done = 1'b1;
      end else if (finish) begin
        got_fin_cyc = cyc;
        got_fail    = fail;
        got_idx     = fail_index;
        check("finish_cyc", 64'(cyc), ref_fail ? 64'(10 * ref_last + 10) : 64'(321));
        check("fail", {63'd0, fail}, {63'd0, ref_fail});
        check("fail_index", {56'd0, fail_index}, ref_fail ? 64'(ref_last) : 64'd0);
        check("d_writes", 64'(nd), 64'(ref_last + 1));
        check("s_writes", 64'(ns), 64'(2 * (ref_last + 1)));
        @(negedge clk);
        check("finish_pulse", {63'd0, finish}, 64'd0);
        check("fail_hold", {63'd0, fail}, {63'd0, ref_fail});
        for (int a = 0; a < 256; a++) check("s_final", {56'd0, s_mem[a]}, {56'd0, ref_s[a]});
        for (int k = 0; k <= ref_last; k++) check("d_mem", {56'd0, d_mem[k]}, {56'd0, ref_d[k]});
        done = 1'b1;
      end
    end
    check("run_ended", {63'd0, done}, 64'd1);
  endtask

  task automatic do_run(input int rst_cyc);
    load_mems();
    launch();
    watch_run(rst_cyc);
  endtask

  task automatic check_plain(input int last);
    for (int k = 0; k <= last; k++) check("plaintext", {56'd0, d_mem[k]}, {56'd0, p_img[k]});
  endtask

  initial begin
    int pos;
    reset = 1'b1; start = 1'b0; load_mem = 1'b0; hold_start = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outs", all_outs(), 64'd0);
    reset = 1'b0;

    // Identity S, first byte 'a' accepted, second byte 0x60 aborts.
    identity_s();
    e_img[0] = 8'h63;
    e_img[1] = 8'h65;
    ref_model(1'b1);
    do_run(0);
    check("id2_d0", {56'd0, d_mem[0]}, 64'h61);
    check("id2_d1", {56'd0, d_mem[1]}, 64'h60);
    check("id2_fidx", {56'd0, got_idx}, 64'd1);
    check("id2_fin", 64'(got_fin_cyc), 64'd20);

    // Identity S, zero ciphertext aborts on byte 0.
    identity_s();
    ref_model(1'b1);
    do_run(0);
    check("id3_d0", {56'd0, d_mem[0]}, 64'h02);
    check("id3_fail", {63'd0, got_fail}, 64'd1);
    check("id3_fidx", {56'd0, got_idx}, 64'd0);
    check("id3_fin", 64'(got_fin_cyc), 64'd10);

    // Key 24'h000249 after init+shuffle, full printable message.
    ksa(24'h000249);
    make_cipher(-1);
    do_run(0);
    check_plain(31);
    check("key_fail", {63'd0, got_fail}, 64'd0);
    check("key_fin", 64'(got_fin_cyc), 64'd321);

    // Random keys, about half with a planted invalid byte.
    for (int n = 0; n < 6; n++) begin
      ksa(24'($urandom));
      pos = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 31)) : -1;
      make_cipher(pos);
      do_run(0);
      check_plain(pos >= 0 ? pos : 31);
      check("rand_fail", {63'd0, got_fail}, {63'd0, pos >= 0});
      check("rand_fidx", {56'd0, got_idx}, pos >= 0 ? 64'(pos) : 64'd0);
    end

    // Reset mid-run, then a fresh run from whatever S was left behind.
    ksa(24'($urandom));
    make_cipher(-1);
    do_run(15);
    s_img = s_mem;
    make_cipher(-1);
    do_run(0);
    check_plain(31);

    // Start held high: second run begins right after finish, with fail cleared.
    identity_s();
    ref_model(1'b1);
    hold_start = 1'b1;
    do_run(0);
    check("hold_run1_fail", {63'd0, got_fail}, 64'd1);
    s_img = s_mem;
    ref_model(1'b1);
    hold_start = 1'b0;
    @(posedge clk);
    watch_run(0);
    check("hold_run2_fin", 64'(got_fin_cyc), 64'd10);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
